// File: rtl/rf_addr_pkg.sv
// Shared encodings and helpers for the register-address sequencer.
package rf_addr_pkg;

  typedef enum logic [1:0] {
    SELA_RN  = 2'd0,
    SELA_RD  = 2'd1,
    SELA_R15 = 2'd2,
    SELA_SEQ = 2'd3
  } sel_a_e;

  typedef enum logic [2:0] {
    SELC_RD  = 3'd0,
    SELC_RN  = 3'd1,
    SELC_R14 = 3'd2,
    SELC_R15 = 3'd3,
    SELC_SEQ = 3'd4
  } sel_c_e;

  localparam int REG_LR = 14;
  localparam int REG_PC = 15;

  // Sized for the widest legal list (32); callers zero-extend and truncate.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module lsb_prio_enc #(
  parameter int W  = 16,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downward so the lowest set bit is the last to write idx.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rf_addr_seq.sv
// A/C register-address muxes with an LDM/STM block-transfer sequencer
// that walks the IR register list in ascending order.
module rf_addr_seq
  import rf_addr_pkg::*;
#(
  parameter int NREG       = 16,
  parameter int RA_W       = $clog2(NREG),
  parameter int LIST_W     = 16,
  parameter int WORD_BYTES = 4,
  parameter int OFF_W      = $clog2(LIST_W * WORD_BYTES) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ir,
  input  logic [1:0]      sel_a,
  input  logic [2:0]      sel_c,
  input  logic            start,
  input  logic            step,
  output logic [RA_W-1:0] addr_a,
  output logic [RA_W-1:0] addr_c,
  output logic            busy,
  output logic            last,
  output logic            done,
  output logic [RA_W:0]   count,
  output logic [OFF_W-1:0] offset
);

  localparam int IW = (LIST_W > 1) ? $clog2(LIST_W) : 1;
  localparam int CW = RA_W + 1;

  logic [LIST_W-1:0] mask;
  logic [LIST_W-1:0] list;
  logic [IW-1:0]     enc_idx;
  logic              enc_valid;
  logic [RA_W-1:0]   cur;
  logic [RA_W-1:0]   rn, rd;
  logic              unused;

  assign list   = ir[LIST_W-1:0];
  assign rn     = RA_W'(ir[19:16]);
  assign rd     = RA_W'(ir[15:12]);
  assign unused = ^ir[31:20];

  lsb_prio_enc #(.W(LIST_W), .IW(IW)) u_enc (
    .vec   (mask),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign cur  = enc_valid ? RA_W'(enc_idx) : '0;
  assign last = busy & enc_valid & ((mask & (mask - 1'b1)) == '0);

  always_comb begin
    addr_a = rn;
    case (sel_a_e'(sel_a))
      SELA_RN:  addr_a = rn;
      SELA_RD:  addr_a = rd;
      SELA_R15: addr_a = RA_W'(REG_PC);
      SELA_SEQ: addr_a = cur;
      default:  addr_a = rn;
    endcase
  end

  always_comb begin
    addr_c = '0;
    case (sel_c_e'(sel_c))
      SELC_RD:  addr_c = rd;
      SELC_RN:  addr_c = rn;
      SELC_R14: addr_c = RA_W'(REG_LR);
      SELC_R15: addr_c = RA_W'(REG_PC);
      SELC_SEQ: addr_c = cur;
      default:  addr_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      offset <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        // start outranks step in idle; an empty list completes immediately.
        if (start) begin
          count  <= CW'(popcount(32'(list)));
          offset <= '0;
          if (list != '0) begin
            mask <= list;
            busy <= 1'b1;
          end else begin
            done <= 1'b1;
          end
        end
      end else if (step) begin
        mask <= mask & (mask - 1'b1);
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          offset <= offset + OFF_W'(WORD_BYTES);
        end
      end
    end
  end

endmodule
